wr_sram_match_engine: RTL and testbench

Parametrised SRAM selection engine for the port write path. On a front-end request it drives its own round-robin scan index across all SRAMs. For each scanned SRAM it samples the back end's status (accessible, free space, per-port packet count) and keeps the best candidate under a selectable policy. It reports either a one-cycle success with the chosen SRAM or a one-cycle failure after a programmable timeout.

---
 rtl/wr_sram_match_engine_if.sv | 28 ++
 rtl/wr_sram_match_engine.sv | 132 +++++++++++++
 tb/tb_wr_sram_match_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wr_sram_match_engine_if.sv
// Request and SRAM-status bus of the write-path SRAM match engine.
// The slave side is the engine. The master side is the front end plus the status back end.
interface wr_sram_match_engine_if #(
  parameter int IDX_W   = 5,
  parameter int LEN_W   = 6,
  parameter int SPACE_W = 11,
  parameter int AMT_W   = 9
);
  logic               match_enable;
  logic [LEN_W-1:0]   new_length;
  logic               match_suc;
  logic               match_fail;
  logic [IDX_W:0]     match_best_sram;
  logic [IDX_W-1:0]   scan_sram;
  logic               accessible;
  logic [SPACE_W-1:0] free_space;
  logic [AMT_W-1:0]   packet_amount;

  modport slave (
    input  match_enable, new_length, accessible, free_space, packet_amount,
    output match_suc, match_fail, match_best_sram, scan_sram
  );

  modport master (
    output match_enable, new_length, accessible, free_space, packet_amount,
    input  match_suc, match_fail, match_best_sram, scan_sram
  );
endinterface

// File: rtl/wr_sram_match_engine.sv
// Round-robin SRAM selection for the write path.
// Scans one SRAM per cycle, keeps the best candidate under the selected policy, and reports success or timeout.
module wr_sram_match_engine #(
  parameter int SRAM_NUM = 32,
  parameter int IDX_W    = 5,
  parameter int LEN_W    = 6,
  parameter int SPACE_W  = 11,
  parameter int AMT_W    = 9,
  parameter int TICK_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TICK_W-1:0]    match_threshold,
  input  logic [TICK_W-1:0]    match_timeout,
  input  logic [1:0]           match_mode,
  wr_sram_match_engine_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_FAIL} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SRAM_NUM - 1);
  localparam logic [IDX_W:0]   NONE     = (IDX_W+1)'(SRAM_NUM);

  state_t             state_reg;
  logic [TICK_W-1:0]  tick_reg;
  logic               find_reg;
  logic [AMT_W-1:0]   best_amt_reg;
  logic [SPACE_W-1:0] best_space_reg;
  logic [IDX_W:0]     best_reg;
  logic [IDX_W-1:0]   scan_reg;
  logic [IDX_W-1:0]   base_reg;
  logic               suc_reg;
  logic               fail_reg;

  logic [LEN_W:0]     need_len;
  logic               qualify;
  logic               better;
  logic               take;
  logic               find_done;
  logic [IDX_W-1:0]   scan_next;
  logic [IDX_W-1:0]   base_next;

  // One extra bit keeps all-ones length + 1 from wrapping to zero.
  assign need_len = {1'b0, bus.new_length} + {{LEN_W{1'b0}}, 1'b1};
  assign qualify  = bus.accessible && (bus.free_space >= SPACE_W'(need_len));

  always_comb begin
    better = 1'b0;
    case (match_mode)
      2'd1:    better = bus.free_space > best_space_reg;
      2'd2:    better = !find_reg;
      default: better = bus.packet_amount >= best_amt_reg;
    endcase
  end

  assign take      = qualify && better;
  assign find_done = find_reg && ((match_mode == 2'd2) || (tick_reg >= match_threshold));
  assign scan_next = (scan_reg == LAST_IDX) ? '0 : scan_reg + 1'b1;
  assign base_next = (best_reg[IDX_W-1:0] == LAST_IDX) ? '0 : best_reg[IDX_W-1:0] + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      tick_reg       <= '0;
      find_reg       <= 1'b0;
      best_amt_reg   <= '0;
      best_space_reg <= '0;
      best_reg       <= NONE;
      scan_reg       <= '0;
      base_reg       <= '0;
      suc_reg        <= 1'b0;
      fail_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          suc_reg  <= 1'b0;
          fail_reg <= 1'b0;
          scan_reg <= base_reg;
          if (bus.match_enable) begin
            state_reg      <= S_SCAN;
            tick_reg       <= '0;
            find_reg       <= 1'b0;
            best_amt_reg   <= '0;
            best_space_reg <= '0;
            best_reg       <= NONE;
          end
        end
        S_SCAN: begin
          if (!bus.match_enable) begin
            state_reg <= S_IDLE;
            best_reg  <= NONE;
            scan_reg  <= base_reg;
          end else begin
            scan_reg <= scan_next;
            if (tick_reg != '1)
              tick_reg <= tick_reg + 1'b1;
            // The SRAM on the exit cycle is still evaluated; the exit itself uses registered find.
            if (take) begin
              best_reg       <= {1'b0, scan_reg};
              best_amt_reg   <= bus.packet_amount;
              best_space_reg <= bus.free_space;
              find_reg       <= 1'b1;
            end
            if (find_done) begin
              state_reg <= S_DONE;
              suc_reg   <= 1'b1;
            end else if (!find_reg && (tick_reg == match_timeout)) begin
              state_reg <= S_FAIL;
              fail_reg  <= 1'b1;
              best_reg  <= NONE;
            end
          end
        end
        S_DONE: begin
          suc_reg   <= 1'b0;
          base_reg  <= base_next;
          scan_reg  <= base_next;
          state_reg <= S_IDLE;
        end
        default: begin
          fail_reg  <= 1'b0;
          scan_reg  <= base_reg;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.match_suc       = suc_reg;
  assign bus.match_fail      = fail_reg;
  assign bus.match_best_sram = best_reg;
  assign bus.scan_sram       = scan_reg;
endmodule

// File: tb/tb_wr_sram_match_engine.sv
// Randomized and directed bench for wr_sram_match_engine against a tick-level reference model.
module tb_wr_sram_match_engine;
  localparam int SRAM_NUM = 32;
  localparam int IDX_W    = 5;
  localparam int LEN_W    = 6;
  localparam int SPACE_W  = 11;
  localparam int AMT_W    = 9;
  localparam int TICK_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [TICK_W-1:0] match_threshold = '0;
  logic [TICK_W-1:0] match_timeout = '0;
  logic [1:0]        match_mode = '0;

  wr_sram_match_engine_if #(.IDX_W(IDX_W), .LEN_W(LEN_W), .SPACE_W(SPACE_W), .AMT_W(AMT_W)) bus ();

  wr_sram_match_engine #(
    .SRAM_NUM(SRAM_NUM), .IDX_W(IDX_W), .LEN_W(LEN_W),
    .SPACE_W(SPACE_W), .AMT_W(AMT_W), .TICK_W(TICK_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .match_threshold(match_threshold),
    .match_timeout(match_timeout),
    .match_mode(match_mode),
    .bus(bus)
  );

  always #5 clk = ~clk;

  bit acc_m [SRAM_NUM];
  int fs_m  [SRAM_NUM];
  int amt_m [SRAM_NUM];

  // Back end answers for whatever SRAM the engine addresses this cycle.
  always_comb begin
    bus.accessible    = acc_m[bus.scan_sram];
    bus.free_space    = SPACE_W'(fs_m[bus.scan_sram]);
    bus.packet_amount = AMT_W'(amt_m[bus.scan_sram]);
  end

  int n_pass  = 0;
  int n_total = 0;
  int base_m  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic bit qual(input int idx, input int len);
    return acc_m[idx] && (fs_m[idx] >= len + 1);
  endfunction

  // Outcome of a request issued from IDLE: success/failure, the tick at which the
  // decision is taken (pulse appears one edge later), and the chosen SRAM.
  task automatic model(input int base, input int mode, input int thr, input int tmo, input int len,
                       output bit suc, output int t_evt, output int best);
    int ff;
    int bamt;
    int bsp;
    int idx;
    ff = -1;
    for (int t = 0; t < tmo; t++) begin
      if (qual((base + t) % SRAM_NUM, len)) begin
        ff = t;
        break;
      end
    end
    if (ff < 0) begin
      suc = 1'b0; t_evt = tmo; best = SRAM_NUM;
      return;
    end
    suc   = 1'b1;
    t_evt = (mode == 2) ? ff + 1 : ((thr > ff + 1) ? thr : ff + 1);
    best  = SRAM_NUM; bamt = -1; bsp = 0;
    for (int t = 0; t <= t_evt; t++) begin
      idx = (base + t) % SRAM_NUM;
      if (qual(idx, len)) begin
        if (mode == 2) begin
          if (best == SRAM_NUM) best = idx;
        end else if (mode == 1) begin
          if (fs_m[idx] > bsp) begin best = idx; bsp = fs_m[idx]; end
        end else begin
          if (amt_m[idx] >= bamt) begin best = idx; bamt = amt_m[idx]; end
        end
      end
    end
  endtask

  task automatic run_req(input string tag, input int mode, input int thr, input int tmo, input int len);
    bit suc_e;
    int t_e;
    int best_e;
    int n;
    model(base_m, mode, thr, tmo, len, suc_e, t_e, best_e);
    check({tag, " idle_scan"}, int'(bus.scan_sram), base_m);
    match_mode      = 2'(mode);
    match_threshold = TICK_W'(thr);
    match_timeout   = TICK_W'(tmo);
    bus.new_length  = LEN_W'(len);
    bus.match_enable = 1'b1;
    n = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.match_suc || bus.match_fail) begin n = i; break; end
    end
    check({tag, " latency"}, n, t_e + 1);
    check({tag, " suc"}, int'(bus.match_suc), int'(suc_e));
    check({tag, " fail"}, int'(bus.match_fail), int'(!suc_e));
    check({tag, " best"}, int'(bus.match_best_sram), best_e);
    bus.match_enable = 1'b0;
    @(posedge clk); #1;
    if (suc_e) base_m = (best_e + 1) % SRAM_NUM;
    check({tag, " one_pulse"}, int'(bus.match_suc | bus.match_fail), 0);
    check({tag, " best_hold"}, int'(bus.match_best_sram), best_e);
    check({tag, " next_base"}, int'(bus.scan_sram), base_m);
    $display("req %s mode=%0d thr=%0d tmo=%0d len=%0d -> suc=%0d tick=%0d best=%0d", tag, mode, thr, tmo, len,
             suc_e, t_e, best_e);
  endtask

  task automatic fill(input bit acc, input int fs, input int amt_is_idx);
    for (int i = 0; i < SRAM_NUM; i++) begin
      acc_m[i] = acc;
      fs_m[i]  = fs;
      amt_m[i] = amt_is_idx ? i : 0;
    end
  endtask

  initial begin
    int pulses;
    int len;
    int dens;
    bus.match_enable = 1'b0;
    bus.new_length   = '0;
    fill(1'b0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst suc", int'(bus.match_suc), 0);
    check("rst fail", int'(bus.match_fail), 0);
    check("rst best", int'(bus.match_best_sram), SRAM_NUM);
    check("rst scan", int'(bus.scan_sram), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(1'b1, 100, 1);
    run_req("mode0_thr4", 0, 4, 200, 10);
    check("mode0 best literal", int'(bus.match_best_sram), 4);

    fill(1'b1, 200, 0);
    fs_m[3] = 500;
    run_req("mode1_single", 1, 40, 200, 10);
    check("mode1 best literal", int'(bus.match_best_sram), 3);

    // Reset mid-scan: no pulse, no candidate, base back to 0.
    fill(1'b0, 0, 0);
    match_timeout    = 8'd100;
    bus.match_enable = 1'b1;
    repeat (6) @(posedge clk);
    rst_n = 1'b0;
    bus.match_enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base_m = 0;
    check("rst_mid pulse", int'(bus.match_suc | bus.match_fail), 0);
    check("rst_mid best", int'(bus.match_best_sram), SRAM_NUM);
    check("rst_mid scan", int'(bus.scan_sram), 0);
    @(posedge clk); #1;

    fill(1'b1, 200, 0);
    fs_m[3] = 500;
    fs_m[7] = 500;
    run_req("mode1_tie", 1, 40, 200, 10);
    check("mode1 tie literal", int'(bus.match_best_sram), 3);

    fill(1'b0, 100, 0);
    acc_m[9] = 1'b1;
    run_req("mode2_only9", 2, 40, 200, 10);
    check("mode2 best literal", int'(bus.match_best_sram), 9);

    fill(1'b1, 10, 0);
    run_req("timeout20", 0, 4, 20, 10);

    fill(1'b1, 63, 0);
    fs_m[(base_m + 30) % SRAM_NUM] = 64;
    run_req("len63", 2, 0, 100, 63);

    // Abort mid-scan: no pulse, no candidate, base unchanged.
    fill(1'b0, 0, 0);
    match_timeout    = 8'd100;
    bus.match_enable = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      pulses += int'(bus.match_suc | bus.match_fail);
    end
    bus.match_enable = 1'b0;
    @(posedge clk); #1;
    pulses += int'(bus.match_suc | bus.match_fail);
    check("abort pulses", pulses, 0);
    check("abort best", int'(bus.match_best_sram), SRAM_NUM);
    check("abort scan", int'(bus.scan_sram), base_m);

    fill(1'b1, 100, 1);
    run_req("after_abort", 0, 3, 50, 20);

    for (int k = 0; k < 40; k++) begin
      len  = $urandom_range(0, 63);
      dens = $urandom_range(1, 8);
      for (int i = 0; i < SRAM_NUM; i++) begin
        acc_m[i] = ($urandom_range(0, 15) < dens);
        fs_m[i]  = len + $urandom_range(0, 3) - 1 + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 1500) : 0);
        if (fs_m[i] < 0) fs_m[i] = 0;
        amt_m[i] = $urandom_range(0, 7);
      end
      run_req($sformatf("rand%0d", k), $urandom_range(0, 3), $urandom_range(0, 40),
              $urandom_range(0, 60), len);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
